// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Holds FSM state encodings, keyboard command bytes and frame bit positions.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_FRAME,
    ST_WAIT_IDLE
  } tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_ECHO    = 8'hEE;

  // Device clock falls already seen, counted from the first falling edge.
  localparam logic [3:0] BIT_LAST_DATA = 4'd8;
  localparam logic [3:0] BIT_PARITY    = 4'd9;

  function automatic logic odd_parity(input logic [7:0] value);
    return ~^value;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Synchronises the raw PS/2 clock and data pads, de-glitches the clock line
// and produces a one-cycle pulse on each accepted falling edge of the clock.
module ps2_host_tx_line_sync #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_filt,
  output logic data_sync,
  output logic clk_fall
);

  localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_CYCLES - 1);

  logic [1:0]    clk_meta;
  logic [1:0]    data_meta;
  logic [FW-1:0] flt_cnt;
  logic          clk_filt_d;

  // A new clock level is only accepted after FILTER_CYCLES consecutive samples
  // disagree with the current one; idle lines reset to the released (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta   <= 2'b11;
      data_meta  <= 2'b11;
      flt_cnt    <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_meta   <= {clk_meta[0], ps2_clk_in};
      data_meta  <= {data_meta[0], ps2_data_in};
      clk_filt_d <= clk_filt;
      if (clk_meta[1] != clk_filt) begin
        if (flt_cnt == FLT_LAST) begin
          clk_filt <= clk_meta[1];
          flt_cnt  <= '0;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign data_sync = data_meta[1];
  assign clk_fall  = clk_filt_d & ~clk_filt;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then
// shifts one command byte out on device clock falls and checks the device ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  import ps2_host_tx_pkg::*;

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic clk_filt;
  logic data_sync;
  logic clk_fall;

  ps2_host_tx_line_sync #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_line_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_filt   (clk_filt),
    .data_sync  (data_sync),
    .clk_fall   (clk_fall)
  );

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       bit_n, bit_n_n;
  logic [7:0]       shift, shift_n;
  logic             parity, parity_n;
  logic             clk_oe, clk_oe_n;
  logic             data_oe, data_oe_n;
  logic             done_q, done_n;
  logic             err_q, err_n;
  logic             ack_q, ack_n;
  logic             timed_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_n   <= '0;
      shift   <= '0;
      parity  <= 1'b0;
      clk_oe  <= 1'b0;
      data_oe <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_n   <= bit_n_n;
      shift   <= shift_n;
      parity  <= parity_n;
      clk_oe  <= clk_oe_n;
      data_oe <= data_oe_n;
      done_q  <= done_n;
      err_q   <= err_n;
      ack_q   <= ack_n;
    end
  end

  // Shared cycle counter: inhibit length in INHIBIT, device-clock timeout after.
  assign timed_out = !clk_fall && (cnt == TO_LAST);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n_n   = bit_n;
    shift_n   = shift;
    parity_n  = parity;
    clk_oe_n  = clk_oe;
    data_oe_n = data_oe;
    done_n    = 1'b0;
    err_n     = 1'b0;
    ack_n     = ack_q;

    case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_n  = tx_data;
          parity_n = odd_parity(tx_data);
          clk_oe_n = 1'b1;
          cnt_n    = '0;
          state_n  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (cnt == INH_LAST) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          cnt_n     = '0;
          bit_n_n   = '0;
          state_n   = ST_REQ;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_REQ, ST_FRAME, ST_WAIT_IDLE: begin
        cnt_n = clk_fall ? '0 : cnt + 1'b1;
        if (timed_out) begin
          err_n     = 1'b1;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          cnt_n     = '0;
          state_n   = ST_IDLE;
        end else if (state == ST_REQ) begin
          if (clk_fall) begin
            bit_n_n   = 4'd1;
            data_oe_n = ~shift[0];
            shift_n   = {1'b0, shift[7:1]};
            state_n   = ST_FRAME;
          end
        end else if (state == ST_FRAME) begin
          // Falls 2..8 carry data bits 1..7, 9 parity, 10 stop, 11 the device ack.
          if (clk_fall) begin
            bit_n_n = bit_n + 4'd1;
            if (bit_n < BIT_LAST_DATA) begin
              data_oe_n = ~shift[0];
              shift_n   = {1'b0, shift[7:1]};
            end else if (bit_n == BIT_LAST_DATA) begin
              data_oe_n = ~parity;
            end else if (bit_n == BIT_PARITY) begin
              data_oe_n = 1'b0;
            end else begin
              ack_n   = ~data_sync;
              state_n = ST_WAIT_IDLE;
            end
          end
        end else begin
          if (clk_filt && data_sync) begin
            done_n  = 1'b1;
            cnt_n   = '0;
            state_n = ST_IDLE;
          end
        end
      end

      default: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        cnt_n     = '0;
        state_n   = ST_IDLE;
      end
    endcase
  end

  assign tx_ready    = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign ack_ok      = ack_q;
  assign ps2_clk_oe  = clk_oe;
  assign ps2_data_oe = data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a simple PS/2 keyboard model that
// clocks frames in after seeing a request-to-send and samples bits on rising edges.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 600;
  localparam int FILT = 8;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       err;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       dev_clk_low;
  logic       dev_data_low;
  logic       ps2_clk_pad;
  logic       ps2_data_pad;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  logic last_ack = 1'b0;

  // Open-drain bus: a line is low whenever either side pulls it.
  assign ps2_clk_pad  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_pad = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_CYCLES (FILT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .err        (err),
    .ps2_clk_in (ps2_clk_pad),
    .ps2_data_in(ps2_data_pad),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      last_ack = ack_ok;
    end
    if (err) err_cnt = err_cnt + 1;
    if (done && err) both_cnt = both_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] value);
    tx_data  = value;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  // Keyboard model; rst_at aborts the frame with a host reset during that clock's low phase.
  task automatic runDevice(input int clocks, input bit do_ack, input int rst_at,
                           input int glitch_at, output logic [9:0] bits);
    int k;
    bits = '0;
    k = 0;
    while (!(ps2_clk_pad && !ps2_data_pad) && k < 2000) begin
      tick(1);
      k++;
    end
    if (k >= 2000) begin
      checkOutput("dev_start_seen", 32'd0, 32'd1);
      return;
    end
    tick(HALF);
    for (int i = 1; i <= clocks; i++) begin
      if (i == 11) begin
        checkOutput("busy_before_clk11", busy, 1);
        if (do_ack) dev_data_low = 1'b1;
      end
      dev_clk_low = 1'b1;
      tick(HALF);
      if (i == rst_at) begin
        checkOutput("data_oe_before_rst", ps2_data_oe, 1);
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("rst_clk_oe", ps2_clk_oe, 0);
        checkOutput("rst_data_oe", ps2_data_oe, 0);
        checkOutput("rst_busy", busy, 0);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        return;
      end
      dev_clk_low = 1'b0;
      if (i <= 10) bits[i-1] = ps2_data_pad;
      if (i == glitch_at) begin
        tick(10);
        dev_clk_low = 1'b1;
        tick(5);
        dev_clk_low = 1'b0;
        tick(HALF - 15);
      end else begin
        tick(HALF);
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic doFrame(input string name, input logic [7:0] value, input logic [9:0] exp_bits,
                         input bit do_ack, input int glitch_at, input bit inject_ff);
    int d0, e0, len, k, exp_len;
    logic [9:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(value);
    checkOutput($sformatf("%s/busy", name), busy, 1);
    checkOutput($sformatf("%s/ready", name), tx_ready, 0);
    exp_len = INH;
    if (inject_ff) begin
      tick(5);
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      exp_len  = INH - 6;
    end
    len = 0;
    while (ps2_clk_oe && len < 1000) begin
      len++;
      tick(1);
    end
    checkOutput($sformatf("%s/inhibit_len", name), len, exp_len);
    checkOutput($sformatf("%s/start_bit", name), ps2_data_oe, 1);
    runDevice(11, do_ack, 0, glitch_at, bits);
    k = 0;
    while (done_cnt == d0 && k < 1000) begin
      tick(1);
      k++;
    end
    checkOutput($sformatf("%s/bits", name), bits, exp_bits);
    checkOutput($sformatf("%s/done_count", name), done_cnt - d0, 1);
    checkOutput($sformatf("%s/ack_ok", name), last_ack, do_ack);
    checkOutput($sformatf("%s/no_err", name), err_cnt - e0, 0);
    checkOutput($sformatf("%s/ready_after", name), tx_ready, 1);
  endtask

  initial begin
    int d0, e0, k;
    logic [9:0] bits;
    rst          = 1'b1;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    checkOutput("reset/tx_ready", tx_ready, 1);
    checkOutput("reset/busy", busy, 0);
    checkOutput("reset/done", done, 0);
    checkOutput("reset/ack_ok", ack_ok, 0);
    checkOutput("reset/err", err, 0);
    checkOutput("reset/clk_oe", ps2_clk_oe, 0);
    checkOutput("reset/data_oe", ps2_data_oe, 0);
    tick(20);

    // {stop, parity, data} as seen by the keyboard
    doFrame("ED", 8'hED, 10'h3ED, 1'b1, 0, 1'b0);
    tick(50);
    doFrame("01", 8'h01, 10'h201, 1'b1, 0, 1'b0);
    tick(50);
    doFrame("00", 8'h00, 10'h300, 1'b1, 0, 1'b0);
    tick(50);

    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(8'hF4);
    k = 0;
    while (ps2_clk_oe && k < 1000) begin
      k++;
      tick(1);
    end
    k = 0;
    while (!err && k < 5000) begin
      tick(1);
      k++;
    end
    checkOutput("timeout/cycles", k, TO);
    checkOutput("timeout/clk_oe", ps2_clk_oe, 0);
    checkOutput("timeout/data_oe", ps2_data_oe, 0);
    tick(1);
    checkOutput("timeout/err_pulse", err, 0);
    checkOutput("timeout/tx_ready", tx_ready, 1);
    checkOutput("timeout/err_count", err_cnt - e0, 1);
    checkOutput("timeout/no_done", done_cnt - d0, 0);
    tick(50);

    doFrame("EE_nack", 8'hEE, 10'h3EE, 1'b0, 0, 1'b0);
    tick(50);

    d0 = done_cnt;
    e0 = err_cnt;
    applyStimulus(8'hED);
    k = 0;
    while (ps2_clk_oe && k < 1000) begin
      k++;
      tick(1);
    end
    runDevice(11, 1'b1, 5, 0, bits);
    tick(TO + 100);
    checkOutput("rst/no_done", done_cnt - d0, 0);
    checkOutput("rst/no_err", err_cnt - e0, 0);
    checkOutput("rst/tx_ready", tx_ready, 1);
    doFrame("F4_after_rst", 8'hF4, 10'h2F4, 1'b1, 0, 1'b0);
    tick(50);

    doFrame("3C_glitch", 8'h3C, 10'h33C, 1'b1, 3, 1'b1);
    tick(20);

    checkOutput("done_err_overlap", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
